// File: rtl/fpgano_pkg.sv
// fpgano_pkg: keypad geometry and row-scan state encoding shared by scanner, scorer and tone player
package fpgano_pkg;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int N_KEYS = 16;
    typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2, ROW3 = 2'd3} row_state_t;
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus debounced key outputs
interface keypad_scanner_if;
    import fpgano_pkg::*;
    logic [N_COLS-1:0] cols;
    logic [N_ROWS-1:0] rows;
    logic [N_KEYS-1:0] pad;
    logic [3:0]        key_code;
    logic              press;
    logic              multi;
    modport master(input cols, output rows, pad, key_code, press, multi);
    modport slave(output cols, input rows, pad, key_code, press, multi);
endinterface

// File: rtl/sync2.sv
// sync2: parameterized-width two-flop synchronizer with a selectable reset value
module sync2 #(
    parameter int W = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk)
        if (rst) {q, meta} <= {INIT, INIT};
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed 4x4 keypad scan with whole-scan debounce and one-hot key decode
module keypad_scanner
    import fpgano_pkg::*;
#(
    parameter int ROW_CYCLES     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic              CLOCK_50,
    input logic              reset,
    keypad_scanner_if.master kp
);
    localparam int TW = $clog2(ROW_CYCLES);
    row_state_t        state, state_nxt;
    logic [TW-1:0]     timer;
    logic [N_COLS-1:0] cols_s;
    logic [N_KEYS-1:0] snap, prev, scan, pad_nxt;
    logic [3:0]        cnt, cnt_nxt, idx;
    logic [4:0]        pop;
    logic              tc, scan_done, take;

    sync2 #(.W(N_COLS), .INIT('1)) u_sync (
        .clk(CLOCK_50),
        .rst(reset),
        .d(kp.cols),
        .q(cols_s)
    );

    assign tc        = timer == TW'(ROW_CYCLES - 1);
    assign scan_done = tc && state == ROW3;
    assign kp.rows   = ~(N_ROWS'(1) << state);

    always_ff @(posedge CLOCK_50)
        if (reset) state <= ROW0;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = tc ? row_state_t'(state + 2'd1) : state;
    end

    // scan = snapshot with the current row's contacts merged in; complete at the ROW3 terminal count
    always_comb begin
        scan = snap;
        scan[{state, 2'b00} +: N_COLS] = ~cols_s;
        pop = '0;
        idx = '0;
        for (int i = 0; i < N_KEYS; i++)
            if (scan[i]) begin
                pop = pop + 5'd1;
                idx = 4'(i);
            end
        pad_nxt = pop == 5'd1 ? scan : '0;
        cnt_nxt = scan != prev ? 4'd1 : cnt == 4'(DEBOUNCE_SCANS) ? cnt : cnt + 4'd1;
        take    = scan_done && cnt_nxt == 4'(DEBOUNCE_SCANS);
    end

    always_ff @(posedge CLOCK_50)
        if (reset) begin
            timer       <= '0;
            snap        <= '0;
            prev        <= '0;
            cnt         <= '0;
            kp.pad      <= '0;
            kp.key_code <= '0;
            kp.press    <= 1'b0;
            kp.multi    <= 1'b0;
        end else begin
            timer    <= tc ? '0 : timer + 1'b1;
            kp.press <= 1'b0;
            if (tc) snap <= scan;
            if (scan_done) begin
                cnt  <= cnt_nxt;
                prev <= scan;
            end
            if (take) begin
                kp.pad   <= pad_nxt;
                kp.multi <= pop > 5'd1;
                kp.press <= pad_nxt != '0 && pad_nxt != kp.pad;
                if (pop == 5'd1) kp.key_code <= idx;
            end
        end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad matrix stimulus with a scan-level debounce model and event scoreboard
module tb_keypad_scanner;
    import fpgano_pkg::*;
    localparam int RC = 4;
    localparam int DB = 3;

    typedef struct packed {
        logic [15:0] pad;
        logic        multi;
        logic [3:0]  kc;
        logic        press;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = '0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          started = 0;
    obs_t        q[$];
    obs_t        m_last, o_last, a;
    logic [15:0] hist[$];
    logic [15:0] deb;
    logic [3:0]  rows_exp;

    keypad_scanner_if kif();

    keypad_scanner #(.ROW_CYCLES(RC), .DEBOUNCE_SCANS(DB)) dut (
        .CLOCK_50(clk),
        .reset(reset),
        .kp(kif.master)
    );

    always #5 clk = ~clk;

    // a column reads low when any held key sits on the row currently driven low
    always_comb begin
        kif.cols = '1;
        for (int c = 0; c < 4; c++)
            kif.cols[c] = ~|(~kif.rows & {keys[12+c], keys[8+c], keys[4+c], keys[c]});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        deb = '0;
        m_last = '0;
    endtask

    // debounced value = snapshot once the last DB scans agree; push an event whenever the decoded outputs change
    task automatic model_step(input logic [15:0] m);
        obs_t e;
        bit same = 1;
        int p;
        hist.push_back(m);
        if (hist.size() > DB) void'(hist.pop_front());
        foreach (hist[i]) if (hist[i] != m) same = 0;
        if (same && hist.size() == DB) deb = m;
        p = $countones(deb);
        e.pad   = p == 1 ? deb : 16'h0;
        e.multi = p > 1;
        e.kc    = p == 1 ? 4'($clog2(deb)) : m_last.kc;
        e.press = 1'b0;
        if ({e.pad, e.multi, e.kc} != {m_last.pad, m_last.multi, m_last.kc}) begin
            e.press = e.pad != 0 && e.pad != m_last.pad;
            q.push_back(e);
        end
        m_last = e;
    endtask

    always @(posedge clk) begin
        #1;
        cyc = reset ? 0 : cyc + 1;
        if (started) begin
            rows_exp = 4'b0001 << ((cyc / RC) % 4);
            check("rows walk", {28'h0, kif.rows}, {28'h0, ~rows_exp});
            if (reset) o_last = '0;
            else if (kif.press || {kif.pad, kif.multi, kif.key_code} != {o_last.pad, o_last.multi, o_last.kc}) begin
                a = {kif.pad, kif.multi, kif.key_code, kif.press};
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected event: got pad=%h multi=%b key_code=%0d press=%b expected none at %0t",
                             a.pad, a.multi, a.kc, a.press, $time);
                end else check("output event", {10'h0, a}, {10'h0, q.pop_front()});
                o_last = a;
            end
        end
    end

    task automatic wait_rows(input logic [3:0] v);
        int n = 0;
        while (kif.rows !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (kif.rows !== v) begin
            checks++;
            errors++;
            $display("FAIL rows wait: got %b required %b", kif.rows, v);
        end
    endtask

    task automatic scan(input logic [15:0] m);
        @(negedge clk);
        wait_rows(4'b0111);
        wait_rows(4'b1110);
        keys = m;
        model_step(m);
    endtask

    task automatic scans(input logic [15:0] m, input int n);
        repeat (n) scan(m);
    endtask

    // call at a negedge; the scan beginning at the last reset edge samples the current keys
    task automatic do_reset(input int n);
        check("queue empty before reset", q.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        check("reset pad", {16'h0, kif.pad}, 0);
        check("reset key_code", {28'h0, kif.key_code}, 0);
        check("reset press", {31'h0, kif.press}, 0);
        check("reset multi", {31'h0, kif.multi}, 0);
        check("reset rows", {28'h0, kif.rows}, 32'he);
        repeat (n - 1) @(negedge clk);
        reset = 1'b0;
        model_reset();
        model_step(keys);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] m;
        int a0;
        started = 1;
        do_reset(3);
        scans(16'h0, 7);
        scans(16'h0040, 4);
        scans(16'h0, 4);
        for (int i = 0; i < 10; i++) scan(i % 2 == 0 ? 16'h0040 : 16'h0);
        scans(16'h0040, 4);
        scans(16'h8001, 4);
        scans(16'h0001, 4);
        scans(16'h0, 4);
        scans(16'h0008, 4);
        scans(16'h0200, 4);
        scans(16'h0, 4);
        scans(16'h0020, 2);
        wait_rows(4'b1011);
        do_reset(1);
        scans(16'h0020, 3);
        scans(16'h0, 4);
        m = '0;
        repeat (40) begin
            case ($urandom_range(0, 3))
                0: m = '0;
                1: m = 16'h1 << $urandom_range(0, 15);
                2: begin
                    a0 = $urandom_range(0, 15);
                    m = (16'h1 << a0) | (16'h1 << ((a0 + $urandom_range(1, 15)) % 16));
                end
                default: ;
            endcase
            scans(m, $urandom_range(1, 5));
        end
        scans(16'h0, 4);
        repeat (8) @(negedge clk);
        check("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
